mdu_iter: RTL

- Iterative multiply/divide unit for MULT, MULTU, DIV and DIVU.
- Sits directly upstream of the HI/LO register pair: takes rs/rt operands from the execute stage and produces the 64-bit {hi, lo} result.
- Raises a one-cycle write strobe that drives the HI/LO write enable with both halves selected.
- Uses sign-magnitude shift-add / restoring-division over 32 iterations.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_divstep.sv | 23 ++
 rtl/mdu_iter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract divisor.
module mdu_divstep
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shl;
  logic           borrow;

  assign shl    = {rem_i, quo_i[WIDTH-1]};
  assign borrow = shl < {1'b0, dvs_i};
  // On success the difference is below the divisor, so WIDTH bits hold it exactly.
  assign rem_o  = borrow ? shl[WIDTH-1:0] : (shl[WIDTH-1:0] - dvs_i);
  assign quo_o  = {quo_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU feeding HI/LO; done strobes WIDTH+2 cycles after start.
// Define MDU_EARLY_OUT_EN to retire multiplies once the remaining multiplier bits are zero.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         state_q;
  mdu_op_e            op_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   a_q, am_q, bm_q, mpl_q;
  logic               sgn_p_q, sgn_r_q;
  logic               busy_q, done_q, div0_q;
  logic [WIDTH-1:0]   lo_q, hi_q;

  mdu_op_e          op_in;
  logic             in_signed;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign op_in     = mdu_op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign a_abs     = (in_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (in_signed && b[WIDTH-1]) ? -b : b;

  logic run_div;
  assign run_div = op_is_div(op_q);

  // Shift-add step: carry out of the upper half re-enters at the top on the shift.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mpl_q[0] ? {1'b0, am_q} : '0);
  assign mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

  logic [WIDTH-1:0] div_rem_d, div_quo_d;

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i (acc_q[2*WIDTH-1:WIDTH]),
    .quo_i (acc_q[WIDTH-1:0]),
    .dvs_i (bm_q),
    .rem_o (div_rem_d),
    .quo_o (div_quo_d)
  );

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = sgn_p_q ? -acc_q : acc_q;
  assign quo_fix  = sgn_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sgn_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= MDU_MULT;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      am_q    <= '0;
      bm_q    <= '0;
      mpl_q   <= '0;
      sgn_p_q <= 1'b0;
      sgn_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            op_q    <= op_in;
            a_q     <= a;
            am_q    <= a_abs;
            bm_q    <= b_abs;
            mpl_q   <= b_abs;
            sgn_p_q <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            sgn_r_q <= in_signed & a[WIDTH-1];
            acc_q   <= op_is_div(op_in) ? {{WIDTH{1'b0}}, a_abs} : '0;
            cnt_q   <= CW'(WIDTH - 1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (run_div) begin
            acc_q <= {div_rem_d, div_quo_d};
          end else begin
            acc_q <= mul_acc_d;
            mpl_q <= mpl_q >> 1;
          end
          if (cnt_q == '0) begin
            state_q <= ST_FIX;
          end
`ifdef MDU_EARLY_OUT_EN
          // Nothing left to add: align the product with the remaining shifts at once.
          if (!run_div && mpl_q == '0) begin
            acc_q   <= (acc_q >> cnt_q) >> 1;
            state_q <= ST_FIX;
          end
`endif
        end
        ST_FIX: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (!run_div) begin
            {hi_q, lo_q} <= prod_fix;
            div0_q       <= 1'b0;
          end else if (bm_q == '0) begin
            lo_q   <= '1;
            hi_q   <= a_q;
            div0_q <= 1'b1;
          end else begin
            lo_q   <= quo_fix;
            hi_q   <= rem_fix;
            div0_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign div0   = div0_q;
  assign out_lo = lo_q;
  assign out_hi = hi_q;

endmodule
